// File: rtl/id_pkg.sv
// Shared constants and helpers for the decode/scoreboard stage.
package id_pkg;

    localparam int NUM_REGS_D = 32;
    localparam int XLEN_D     = 32;
    localparam int IMM_W_D    = 16;
    localparam int WB_PORTS_D = 2;
    localparam int CNT_W_D    = 2;

    localparam logic [CNT_W_D-1:0] CNT_MAX = '1;

    function automatic logic [XLEN_D-1:0] ext_imm(
        input logic [IMM_W_D-1:0] imm,
        input logic               signed_sel
    );
        return {{(XLEN_D-IMM_W_D){signed_sel & imm[IMM_W_D-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_pending_counters.sv
// Per-register pending-write counters: one increment port, WB_PORTS
// decrement ports, saturation flags and a sticky underflow error.
module id_pending_counters
    import id_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int WB_PORTS = WB_PORTS_D,
    parameter int CNT_W    = CNT_W_D,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inc_en,
    input  logic [AW-1:0]                    inc_addr,
    input  logic [WB_PORTS-1:0]              dec_valid,
    input  logic [WB_PORTS*AW-1:0]           dec_addr,
    output logic [NUM_REGS-1:0][CNT_W-1:0]   cnt,
    output logic [NUM_REGS-1:0]              sat,
    output logic                             error
);

    localparam int SW = CNT_W + $clog2(WB_PORTS + 1) + 1;
    localparam logic [SW-1:0] LIM = SW'({CNT_W{1'b1}});

    logic [NUM_REGS-1:0][CNT_W-1:0] nxt;
    logic [NUM_REGS-1:0]            under;
    logic [SW-1:0]                  up   [NUM_REGS];
    logic [SW-1:0]                  dn   [NUM_REGS];
    logic [SW-1:0]                  diff [NUM_REGS];

    // Net change per register; register 0 never counts.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            up[r] = SW'(cnt[r]) +
                    SW'(inc_en && inc_addr == AW'(r) && r != 0);
            dn[r] = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (dec_valid[p] && dec_addr[p*AW +: AW] == AW'(r) && r != 0)
                    dn[r] = dn[r] + SW'(1);
            end
            under[r] = dn[r] > up[r];
            diff[r]  = up[r] - dn[r];
            if (under[r])
                nxt[r] = '0;
            else if (diff[r] > LIM)
                nxt[r] = '1;
            else
                nxt[r] = diff[r][CNT_W-1:0];
            sat[r] = &cnt[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            error <= 1'b0;
        end else begin
            cnt <= nxt;
            if (|under)
                error <= 1'b1;
        end
    end

endmodule

// File: rtl/id_scoreboard_stage.sv
// Decode stage: register file, counting scoreboard, valid/ready output reg.
// Optional same-cycle write-back forwarding: ID_WB_BYPASS_EN.
module id_scoreboard_stage
    import id_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int XLEN     = XLEN_D,
    parameter int IMM_W    = IMM_W_D,
    parameter int WB_PORTS = WB_PORTS_D,
    parameter int CNT_W    = CNT_W_D,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rs,
    input  logic [AW-1:0]            in_rt,
    input  logic [AW-1:0]            in_rd,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic                     in_reg_dst,
    input  logic                     in_reg_write,
    input  logic                     in_imm_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_rs_data,
    output logic [XLEN-1:0]          out_rt_data,
    output logic [XLEN-1:0]          out_imm_ext,
    output logic [XLEN-1:0]          out_imm_shl2,
    output logic [AW-1:0]            out_wr_addr,
    output logic                     out_reg_write,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*AW-1:0]   wb_addr,
    input  logic [WB_PORTS*XLEN-1:0] wb_data,
    input  logic                     flush,
    output logic                     hazard,
    output logic                     sb_error
);

    logic [XLEN-1:0]                regs [NUM_REGS];
    logic [NUM_REGS-1:0][CNT_W-1:0] pend;
    logic [NUM_REGS-1:0]            sat;
    logic [AW-1:0]                  dst;
    logic                           issue;
    logic                           fire;
    logic                           rs_pend, rt_pend;
    logic                           rs_stall, rt_stall, dst_full;
    logic [XLEN-1:0]                rs_val, rt_val, imm_ext;

    assign dst  = in_reg_dst ? in_rd : in_rt;
    assign fire = out_valid && out_ready && !flush;

    id_pending_counters #(
        .NUM_REGS (NUM_REGS),
        .WB_PORTS (WB_PORTS),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (fire && out_reg_write),
        .inc_addr  (out_wr_addr),
        .dec_valid (wb_valid),
        .dec_addr  (wb_addr),
        .cnt       (pend),
        .sat       (sat),
        .error     (sb_error)
    );

`ifdef ID_WB_BYPASS_EN
    logic            rs_hit, rt_hit, rs_byp, rt_byp;
    logic [XLEN-1:0] rs_fwd, rt_fwd;

    // Highest port wins because later iterations overwrite.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_fwd = '0;
        rt_fwd = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && wb_addr[p*AW +: AW] == in_rs && in_rs != '0) begin
                rs_hit = 1'b1;
                rs_fwd = wb_data[p*XLEN +: XLEN];
            end
            if (wb_valid[p] && wb_addr[p*AW +: AW] == in_rt && in_rt != '0) begin
                rt_hit = 1'b1;
                rt_fwd = wb_data[p*XLEN +: XLEN];
            end
        end
    end

    assign rs_byp  = rs_hit && pend[in_rs] == CNT_W'(1);
    assign rt_byp  = rt_hit && pend[in_rt] == CNT_W'(1);
    assign rs_pend = pend[in_rs] != '0 && !rs_byp;
    assign rt_pend = pend[in_rt] != '0 && !rt_byp;
    assign rs_val  = rs_byp ? rs_fwd : regs[in_rs];
    assign rt_val  = rt_byp ? rt_fwd : regs[in_rt];
`else
    assign rs_pend = pend[in_rs] != '0;
    assign rt_pend = pend[in_rt] != '0;
    assign rs_val  = regs[in_rs];
    assign rt_val  = regs[in_rt];
`endif

    // The held output writer has not been counted yet, so check it too.
    assign rs_stall = in_rs != '0 && (rs_pend ||
                      (out_valid && out_reg_write && out_wr_addr == in_rs));
    assign rt_stall = in_rt != '0 && (rt_pend ||
                      (out_valid && out_reg_write && out_wr_addr == in_rt));
    assign dst_full = in_reg_write && dst != '0 && sat[dst];

    assign hazard   = in_valid && (rs_stall || rt_stall || dst_full);
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign issue    = in_valid && in_ready;

    generate
        if (IMM_W == IMM_W_D && XLEN == XLEN_D) begin : g_ext_pkg
            assign imm_ext = ext_imm(in_imm, in_imm_signed);
        end else begin : g_ext_gen
            assign imm_ext = {{(XLEN-IMM_W){in_imm_signed & in_imm[IMM_W-1]}}, in_imm};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && wb_addr[p*AW +: AW] != '0)
                    regs[wb_addr[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_rs_data   <= '0;
            out_rt_data   <= '0;
            out_imm_ext   <= '0;
            out_imm_shl2  <= '0;
            out_wr_addr   <= '0;
            out_reg_write <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (issue)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (issue) begin
                out_rs_data   <= rs_val;
                out_rt_data   <= rt_val;
                out_imm_ext   <= imm_ext;
                out_imm_shl2  <= {imm_ext[XLEN-3:0], 2'b00};
                out_wr_addr   <= dst;
                out_reg_write <= in_reg_write && dst != '0;
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Scoreboard bench for id_scoreboard_stage: directed scenarios then random traffic.
module tb_id_scoreboard_stage;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int WBP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic        in_reg_dst, in_reg_write, in_imm_signed;
    logic        out_valid, out_ready;
    logic [31:0] out_rs_data, out_rt_data, out_imm_ext, out_imm_shl2;
    logic [4:0]  out_wr_addr;
    logic        out_reg_write;
    logic [1:0]  wbv;
    logic [4:0]  wba [WBP];
    logic [31:0] wbd [WBP];
    logic        flush, hazard, sb_error;

    always #5 clk = ~clk;

    id_scoreboard_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_imm        (in_imm),
        .in_reg_dst    (in_reg_dst),
        .in_reg_write  (in_reg_write),
        .in_imm_signed (in_imm_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rs_data   (out_rs_data),
        .out_rt_data   (out_rt_data),
        .out_imm_ext   (out_imm_ext),
        .out_imm_shl2  (out_imm_shl2),
        .out_wr_addr   (out_wr_addr),
        .out_reg_write (out_reg_write),
        .wb_valid      (wbv),
        .wb_addr       ({wba[1], wba[0]}),
        .wb_data       ({wbd[1], wbd[0]}),
        .flush         (flush),
        .hazard        (hazard),
        .sb_error      (sb_error)
    );

    typedef struct packed {
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] ie;
        logic [31:0] is2;
        logic [4:0]  wa;
        logic        we;
    } item_t;

    item_t       q[$];
    int          pend [NR];
    logic [31:0] mreg [NR];
    logic        merr;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef ID_WB_BYPASS_EN
    function automatic bit wb_hits(input logic [4:0] a);
        for (int p = 0; p < WBP; p++)
            if (wbv[p] && wba[p] == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction
`endif

    function automatic bit busy(input logic [4:0] a);
        bit b;
        if (a == 0) return 1'b0;
        b = pend[a] != 0;
`ifdef ID_WB_BYPASS_EN
        if (pend[a] == 1 && wb_hits(a)) b = 1'b0;
`endif
        if (q.size() != 0 && q[0].we && q[0].wa == a) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a);
        logic [31:0] v;
        v = mreg[a];
`ifdef ID_WB_BYPASS_EN
        if (pend[a] == 1)
            for (int p = 0; p < WBP; p++)
                if (wbv[p] && wba[p] == a && a != 0) v = wbd[p];
`endif
        return v;
    endfunction

    // One clock: compare at the falling edge, advance the model, return after rise.
    task automatic step();
        bit          hz, rdy, cons;
        logic [4:0]  dst;
        item_t       it;
        int          up, dn;
        @(negedge clk);
        if (reset) begin
            q.delete();
            for (int r = 0; r < NR; r++) begin
                pend[r] = 0;
                mreg[r] = '0;
            end
            merr = 1'b0;
        end else begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("sb_error", sb_error, merr);
            dst = in_reg_dst ? in_rd : in_rt;
            hz = in_valid && (busy(in_rs) || busy(in_rt) ||
                 (in_reg_write && dst != 0 && pend[dst] == 3));
            rdy = !hz && (q.size() == 0 || out_ready) && !flush;
            chk("hazard", hazard, hz);
            chk("in_ready", in_ready, rdy);
            cons = q.size() != 0 && out_ready && !flush && q[0].we;
            if (in_valid && rdy) begin
                it.rs_d = opnd(in_rs);
                it.rt_d = opnd(in_rt);
                it.ie   = in_imm_signed ? 32'(signed'(in_imm)) : 32'(in_imm);
                it.is2  = it.ie << 2;
                it.wa   = dst;
                it.we   = in_reg_write && dst != 0;
                q.push_back(it);
            end
            for (int r = 1; r < NR; r++) begin
                up = pend[r] + ((cons && q[0].wa == r) ? 1 : 0);
                dn = 0;
                for (int p = 0; p < WBP; p++)
                    if (wbv[p] && wba[p] == r) dn++;
                if (dn > up) begin
                    pend[r] = 0;
                    merr = 1'b1;
                end else begin
                    pend[r] = (up - dn > 3) ? 3 : up - dn;
                end
            end
            for (int p = 0; p < WBP; p++)
                if (wbv[p] && wba[p] != 0) mreg[wba[p]] = wbd[p];
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the held output against the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                chk("rs_data", out_rs_data, q[0].rs_d);
                chk("rt_data", out_rt_data, q[0].rt_d);
                chk("imm_ext", out_imm_ext, q[0].ie);
                chk("imm_shl2", out_imm_shl2, q[0].is2);
                chk("wr_addr", 32'(out_wr_addr), 32'(q[0].wa));
                chk("reg_write", 32'(out_reg_write), 32'(q[0].we));
                if (out_ready || flush) void'(q.pop_front());
            end
        end
    end

    task automatic idle();
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
        in_reg_dst = 0; in_reg_write = 0; in_imm_signed = 0;
        out_ready = 1; flush = 0; wbv = 0;
        for (int p = 0; p < WBP; p++) begin
            wba[p] = 0;
            wbd[p] = 0;
        end
    endtask

    task automatic writer(input logic [4:0] rd);
        idle();
        in_valid = 1; in_rd = rd; in_reg_dst = 1; in_reg_write = 1;
    endtask

    task automatic reader(input logic [4:0] rs);
        idle();
        in_valid = 1; in_rs = rs;
    endtask

    task automatic wb1(input int p, input logic [4:0] a, input logic [31:0] d);
        wbv[p] = 1'b1; wba[p] = a; wbd[p] = d;
    endtask

    initial begin
        int   avail [NR];
        int   r;
        idle();
        reset = 1;
        step(); step();
        reset = 0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rs_data", out_rs_data, 0);
        chk("rst_imm_ext", out_imm_ext, 0);
        chk("rst_wr_addr", 32'(out_wr_addr), 0);
        chk("rst_sb_error", 32'(sb_error), 0);

        idle();
        in_valid = 1; in_rs = 1; in_rt = 2; in_imm = 16'hFFFC; in_imm_signed = 1;
        step();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_imm_ext", out_imm_ext, 32'hFFFFFFFC);
        chk("t1_imm_shl2", out_imm_shl2, 32'hFFFFFFF0);
        idle(); step();

        writer(5); step();
        idle(); step();
        reader(5); #1;
        chk("raw_hazard", 32'(hazard), 1);
        step();
        wb1(0, 5, 32'h1234); #1;
`ifdef ID_WB_BYPASS_EN
        chk("byp_hazard", 32'(hazard), 0);
        step();
        idle();
        chk("byp_rs_data", out_rs_data, 32'h1234);
`else
        chk("wb_cycle_hazard", 32'(hazard), 1);
        step();
        wbv = 0; #1;
        chk("post_wb_hazard", 32'(hazard), 0);
        step();
        idle();
        chk("post_wb_rs_data", out_rs_data, 32'h1234);
`endif
        step();

        writer(7); step(); step(); step();
        idle(); step(); step();
        writer(7); #1;
        chk("sat_hazard", 32'(hazard), 1);
        step();
        wb1(0, 7, 32'h77); step();
        wbv = 0; #1;
        chk("sat_release", 32'(hazard), 0);
        step();
        idle(); step();
        wb1(0, 7, 1); wb1(1, 7, 2); step();
        idle(); wb1(1, 7, 3); step();

        writer(3); step(); step();
        idle(); step(); step();
        wb1(0, 3, 32'hAAAA0000); wb1(1, 3, 32'hBBBB1111); step();
        reader(3); #1;
        chk("dual_wb_hazard", 32'(hazard), 0);
        step();
        idle();
        chk("dual_wb_data", out_rs_data, 32'hBBBB1111);
        step();

        wb1(0, 9, 32'h9); step();
        chk("sb_err_set", 32'(sb_error), 1);
        idle(); step();
        chk("sb_err_sticky", 32'(sb_error), 1);
        reader(9); #1;
        chk("r9_no_hazard", 32'(hazard), 0);
        step();
        idle(); step();

        writer(4); out_ready = 0; step();
        in_valid = 0; step();
        chk("hold_wr_addr", 32'(out_wr_addr), 4);
        flush = 1; step();
        chk("flush_valid", 32'(out_valid), 0);
        reader(4); #1;
        chk("flush_no_hazard", 32'(hazard), 0);
        step();
        chk("flush_reader_valid", 32'(out_valid), 1);
        idle(); step();

        writer(6); step();
        idle(); reset = 1; wb1(0, 6, 32'h66); step();
        reset = 0; idle();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_err", 32'(sb_error), 0);
        reader(6); #1;
        chk("midrst_hazard", 32'(hazard), 0);
        step();
        idle(); step();

        for (int c = 0; c < 800; c++) begin
            idle();
            in_valid      = $urandom_range(99) < 70;
            in_rs         = 5'($urandom_range(7));
            in_rt         = 5'($urandom_range(7));
            in_rd         = 5'($urandom_range(7));
            in_imm        = 16'($urandom);
            in_reg_dst    = 1'($urandom);
            in_reg_write  = 1'($urandom);
            in_imm_signed = 1'($urandom);
            out_ready     = $urandom_range(99) < 75;
            flush         = $urandom_range(99) < 5;
            for (int i = 0; i < NR; i++) avail[i] = pend[i];
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(99) < 40) begin
                    for (int t = 0; t < 8; t++) begin
                        r = $urandom_range(7, 1);
                        if (avail[r] > 0 && !wbv[p]) begin
                            avail[r]--;
                            wb1(p, 5'(r), $urandom);
                        end
                    end
                end else if ($urandom_range(99) < 3) begin
                    wb1(p, 5'($urandom_range(7)), $urandom);
                end
            end
            reset = $urandom_range(99) < 1;
            if (reset) in_valid = 0;
            step();
            reset = 0;
        end

        idle(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
